// File: rtl/spinner_pkg.sv
// Shared types and helpers for the spinner_array rotary-control emulator.
// Acceleration is compiled in only when SPINNER_ACCEL_EN is defined.
package spinner_pkg;

  typedef enum logic [1:0] {
    SP_IDLE  = 2'd0,
    SP_RUN_P = 2'd1,
    SP_RUN_N = 2'd2
  } sp_state_t;

  // Width of the hold counter; never below one bit so a zero-range config still builds.
  function automatic int hold_w(input int step_min, input int step_max, input int acc_shift);
    int w;
    w = $clog2(((step_max - step_min) << acc_shift) + 1);
    hold_w = (w < 1) ? 1 : w;
  endfunction

  function automatic int sat_add(input int pos, input int delta, input int width,
                                 input logic clamp);
    int sum;
    int max_v;
    sum   = pos + delta;
    max_v = (32'sd1 <<< width) - 32'sd1;
    if (clamp) begin
      if (sum < 32'sd0) begin
        sat_add = 32'sd0;
      end else if (sum > max_v) begin
        sat_add = max_v;
      end else begin
        sat_add = sum;
      end
    end else begin
      sat_add = sum & max_v;
    end
  endfunction

endpackage

// File: rtl/spinner_channel.sv
// One spinner channel: run-state FSM, optional hold/acceleration (SPINNER_ACCEL_EN),
// and wrap/clamp position update on each tick.
module spinner_channel
  import spinner_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_MIN  = 1,
  parameter int STEP_MAX  = 8,
  parameter int ACC_SHIFT = 2,
  parameter int ANA_SHIFT = 2,
  parameter int CENTER    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             plus,
  input  logic             minus,
  input  logic             enable,
  input  logic             clamp,
  input  logic             ana_valid,
  input  logic [7:0]       ana_in,
  input  logic             recentre,
  output logic [WIDTH-1:0] angle,
  output logic             moved,
  output logic             dir
);

  sp_state_t          state_q, state_d;
  logic [WIDTH-1:0]   angle_q, angle_d;
  logic               moved_q, moved_d;
  logic               dir_q, dir_d;
  logic signed [31:0] delta;
  logic [31:0]        ana_ext;
  int                 new_pos;
  int                 step;

`ifdef SPINNER_ACCEL_EN
  localparam int HOLD_MAX = (STEP_MAX - STEP_MIN) << ACC_SHIFT;
  localparam int HOLD_W   = hold_w(STEP_MIN, STEP_MAX, ACC_SHIFT);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_base, hold_inc;
  int                step_raw;

  // A reversal or a fresh press starts the hold count from zero before the step is taken.
  always_comb begin
    if (plus ? (state_q == SP_RUN_P) : (state_q == SP_RUN_N)) begin
      hold_base = hold_q;
    end else begin
      hold_base = '0;
    end
    if (int'(hold_base) >= HOLD_MAX) begin
      hold_inc = hold_base;
    end else begin
      hold_inc = hold_base + HOLD_W'(1);
    end
    step_raw = STEP_MIN + int'(hold_base >> ACC_SHIFT);
    step     = (step_raw > STEP_MAX) ? STEP_MAX : step_raw;
  end

  always_comb begin
    if (state_d == SP_IDLE) begin
      hold_d = '0;
    end else if (tick && !recentre) begin
      hold_d = hold_inc;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  always_comb begin
    step = (STEP_MIN > STEP_MAX) ? STEP_MAX : STEP_MIN;
  end
`endif

  assign ana_ext = {{24{ana_in[7]}}, ana_in};

  // Priority: recentre, disable, analog, single button, idle.
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    moved_d = 1'b0;
    dir_d   = dir_q;
    delta   = 32'sd0;
    new_pos = 0;
    if (recentre) begin
      angle_d = WIDTH'(CENTER);
      state_d = SP_IDLE;
    end else if (tick) begin
      if (!enable) begin
        state_d = SP_IDLE;
      end else if (ana_valid && (ana_in != 8'd0)) begin
        delta   = $signed(ana_ext) >>> ANA_SHIFT;
        state_d = SP_IDLE;
      end else if (plus ^ minus) begin
        delta   = plus ? step : -step;
        state_d = plus ? SP_RUN_P : SP_RUN_N;
      end else begin
        state_d = SP_IDLE;
      end
      new_pos = sat_add(int'(angle_q), delta, WIDTH, clamp);
      angle_d = new_pos[WIDTH-1:0];
      if (angle_d != angle_q) begin
        moved_d = 1'b1;
        dir_d   = (delta > 32'sd0);
      end else begin
        moved_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SP_IDLE;
      angle_q <= WIDTH'(CENTER);
      moved_q <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      moved_q <= moved_d;
      dir_q   <= dir_d;
    end
  end

  assign angle = angle_q;
  assign moved = moved_q;
  assign dir   = dir_q;

endmodule

// File: rtl/spinner_array.sv
// N-channel spinner emulator top: strobe edge detect and per-channel packing.
// Define SPINNER_ACCEL_EN to enable hold-based step acceleration.
module spinner_array #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int STEP_MIN  = 1,
  parameter int STEP_MAX  = 8,
  parameter int ACC_SHIFT = 2,
  parameter int ANA_SHIFT = 2,
  parameter int CENTER    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    strobe,
  input  logic [NUM_CH-1:0]       plus,
  input  logic [NUM_CH-1:0]       minus,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clamp,
  input  logic [NUM_CH-1:0]       ana_valid,
  input  logic [8*NUM_CH-1:0]     ana_in,
  input  logic [NUM_CH-1:0]       recentre,
  output logic [WIDTH*NUM_CH-1:0] angle,
  output logic [NUM_CH-1:0]       moved,
  output logic [NUM_CH-1:0]       dir
);

  logic strobe_q, tick_q, tick_d;

  assign tick_d = strobe & ~strobe_q;

  // Registered tick gives exactly one update per rising strobe, however long it stays high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      strobe_q <= strobe;
      tick_q   <= tick_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    spinner_channel #(
      .WIDTH    (WIDTH),
      .STEP_MIN (STEP_MIN),
      .STEP_MAX (STEP_MAX),
      .ACC_SHIFT(ACC_SHIFT),
      .ANA_SHIFT(ANA_SHIFT),
      .CENTER   (CENTER)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick_q),
      .plus     (plus[i]),
      .minus    (minus[i]),
      .enable   (enable[i]),
      .clamp    (clamp[i]),
      .ana_valid(ana_valid[i]),
      .ana_in   (ana_in[8*i +: 8]),
      .recentre (recentre[i]),
      .angle    (angle[WIDTH*i +: WIDTH]),
      .moved    (moved[i]),
      .dir      (dir[i])
    );
  end

endmodule

// File: tb/tb_spinner_array.sv
// Directed bench for spinner_array with a frame-level reference model and per-cycle compare.
module tb_spinner_array;

  localparam int NCH       = 4;
  localparam int W         = 8;
  localparam int STEP_MIN  = 1;
  localparam int STEP_MAX  = 8;
  localparam int ACC_SHIFT = 2;
  localparam int ANA_SHIFT = 2;
  localparam int CENTER    = 0;
  localparam int HOLD_MAX  = (STEP_MAX - STEP_MIN) << ACC_SHIFT;
  localparam int AMAX      = (1 << W) - 1;
`ifdef SPINNER_ACCEL_EN
  localparam int T3_END = 27;
  localparam int T5_CH0 = 27;
`else
  localparam int T3_END = 15;
  localparam int T5_CH0 = 15;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             strobe;
  logic [NCH-1:0]   plus, minus, enable, clamp, ana_valid, recentre;
  logic [8*NCH-1:0] ana_in;
  logic [W*NCH-1:0] angle;
  logic [NCH-1:0]   moved, dir;

  int exp_angle[NCH];
  bit exp_moved[NCH];
  bit exp_dir[NCH];
  int m_hold[NCH];
  int m_run[NCH];

  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  int    lit_seq = 0;
  int    lit_done = 0;
  int    lit_ch, lit_val;
  string lit_name;

  always #5 clk = ~clk;

  spinner_array #(
    .NUM_CH(NCH), .WIDTH(W), .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX),
    .ACC_SHIFT(ACC_SHIFT), .ANA_SHIFT(ANA_SHIFT), .CENTER(CENTER)
  ) dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .plus(plus), .minus(minus),
    .enable(enable), .clamp(clamp), .ana_valid(ana_valid), .ana_in(ana_in),
    .recentre(recentre), .angle(angle), .moved(moved), .dir(dir)
  );

  // Every cycle: all channels against the model; plus any pending hand-computed check.
  always @(negedge clk) begin : cmp
    int c, e, a;
    c = 0;
    e = 0;
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) begin
        a = int'(angle[W*i +: W]);
        c++;
        if (a != exp_angle[i] || moved[i] != exp_moved[i] || dir[i] != exp_dir[i]) begin
          e++;
          $display("FAIL cycle_ch%0d t=%0t: angle/moved/dir got %0d/%b/%b expected %0d/%b/%b",
                   i, $time, a, moved[i], dir[i], exp_angle[i], exp_moved[i], exp_dir[i]);
        end
      end
    end
    if (lit_seq != lit_done) begin
      a = int'(angle[W*lit_ch +: W]);
      c++;
      if (a != lit_val) begin
        e++;
        $display("FAIL %s: angle%0d got %0d expected %0d", lit_name, lit_ch, a, lit_val);
      end
      lit_done <= lit_seq;
    end
    n_cmp <= n_cmp + c;
    n_err <= n_err + e;
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      exp_angle[i] = CENTER;
      exp_moved[i] = 1'b0;
      exp_dir[i]   = 1'b0;
      m_hold[i]    = 0;
      m_run[i]     = 0;
    end
  endtask

  // One strobe's worth of motion for every channel, from the current inputs.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int old, nw, delta, d, step;
      logic [7:0] a8;
      old   = exp_angle[i];
      delta = 0;
      a8    = ana_in[8*i +: 8];
      if (recentre[i]) begin
        exp_angle[i] = CENTER;
        m_hold[i] = 0;
        m_run[i]  = 0;
        continue;
      end
      if (!enable[i]) begin
        m_hold[i] = 0; m_run[i] = 0;
      end else if (ana_valid[i] && a8 != 8'd0) begin
        delta = int'($signed(a8)) >>> ANA_SHIFT;
        m_hold[i] = 0; m_run[i] = 0;
      end else if (plus[i] != minus[i]) begin
        d = plus[i] ? 1 : -1;
        if (m_run[i] != d) m_hold[i] = 0;
`ifdef SPINNER_ACCEL_EN
        step = STEP_MIN + (m_hold[i] >> ACC_SHIFT);
        if (step > STEP_MAX) step = STEP_MAX;
`else
        step = STEP_MIN;
`endif
        delta = d * step;
        if (m_hold[i] < HOLD_MAX) m_hold[i]++;
        m_run[i] = d;
      end else begin
        m_hold[i] = 0; m_run[i] = 0;
      end
      nw = old + delta;
      if (clamp[i]) nw = (nw < 0) ? 0 : ((nw > AMAX) ? AMAX : nw);
      else          nw = ((nw % (AMAX + 1)) + AMAX + 1) % (AMAX + 1);
      exp_moved[i] = (nw != old);
      if (nw != old) exp_dir[i] = (delta > 0);
      exp_angle[i] = nw;
    end
  endtask

  task automatic frame(input int hi);
    @(posedge clk); #1 strobe = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 model_step();
    @(posedge clk); #1 for (int i = 0; i < NCH; i++) exp_moved[i] = 1'b0;
    repeat (hi) @(posedge clk);
    #1 strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic lit(input int ch, input int val, input string nm);
    lit_ch   = ch;
    lit_val  = val;
    lit_name = nm;
    lit_seq++;
    @(negedge clk); #1;
  endtask

  task automatic do_recentre(input logic [NCH-1:0] m);
    @(posedge clk); #1 recentre = m;
    @(posedge clk); #1
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        exp_angle[i] = CENTER; m_hold[i] = 0; m_run[i] = 0;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; strobe = 1'b0;
    plus = '0; minus = '0; enable = '1; clamp = '0; ana_valid = '0; recentre = '0;
    ana_in = '0;
    model_reset();
    chk_en = 1'b1;
    lit(0, CENTER, "reset_angle0");
    @(posedge clk); #1 reset_n = 1'b1;

    // Held plus on channel 0
    plus[0] = 1'b1;
    frame(2); lit(0, 1, "plus_hold_1");
    frame(2); lit(0, 2, "plus_hold_2");
    frame(2); lit(0, 3, "plus_hold_3");
    plus[0] = 1'b0;

    // Wrap below zero, clamp at both ends
    minus[1] = 1'b1; clamp[2] = 1'b1; minus[2] = 1'b1;
    frame(1); lit(1, 255, "wrap_under"); lit(2, 0, "clamp_low");
    minus[1] = 1'b0; clamp[2] = 1'b0;
    frame(1); frame(1); lit(2, 254, "wrap_to_254");
    clamp[2] = 1'b1; minus[2] = 1'b0; plus[2] = 1'b1;
    frame(1); lit(2, 255, "clamp_high_1");
    frame(1); lit(2, 255, "clamp_high_2");
    plus[2] = 1'b0;

    // Twelve held strobes then reversal
    plus[0] = 1'b1;
    for (int k = 0; k < 12; k++) frame(1);
    lit(0, T3_END, "hold_12");
    plus[0] = 1'b0; minus[0] = 1'b1;
    frame(1); lit(0, T3_END - 1, "reversal");
    minus[0] = 1'b0;

    // Analog override on channel 3
    ana_valid[3] = 1'b1; plus[3] = 1'b1; minus[3] = 1'b1;
    ana_in[31:24] = 8'd40;  frame(1); lit(3, 10, "ana_plus40");
    ana_in[31:24] = 8'h80;  frame(1); lit(3, 234, "ana_minus128");
    ana_in[31:24] = 8'd3;   frame(1); lit(3, 234, "ana_plus3_zero");
    ana_in[31:24] = 8'hFF;  frame(1); lit(3, 233, "ana_minus1");
    ana_valid[3] = 1'b0; plus[3] = 1'b0; minus[3] = 1'b0; ana_in = '0;

    // Recentre beats a tick; long strobe gives one update
    plus[1] = 1'b1; plus[0] = 1'b1;
    do_recentre(4'b0010);
    frame(100);
    lit(1, CENTER, "recentre_wins");
    lit(0, T5_CH0, "long_strobe_once");
    recentre = '0; plus[1] = 1'b0;

    // Disabled channel stays frozen
    enable[2] = 1'b0; plus[2] = 1'b1;
    frame(1); lit(2, 255, "disabled_frozen");
    enable[2] = 1'b1; plus[2] = 1'b0;

    // Async reset mid-hold, then first step is STEP_MIN
    repeat (4) frame(1);
    @(posedge clk); #1 reset_n = 1'b0; model_reset();
    lit(0, CENTER, "async_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    frame(1); lit(0, CENTER + STEP_MIN, "post_reset_step");
    plus = '0;
    frame(1);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
